// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 multiplier controller that drives an external Hack ALU.
// Every add and doubling is an ALU operation; the sequencer only routes operands and control bits.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        product_zr,
  output logic        product_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DBL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Control words in {zx,nx,zy,ny,f,no} order.
  localparam logic [5:0] CTRL_ADD    = 6'b000010;
  localparam logic [5:0] CTRL_PASS_X = 6'b001100;
  localparam logic [5:0] CTRL_ZERO   = 6'b101010;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic [5:0]  ctrl;

  // ALU flags are not needed: the sequence length is fixed.
  logic unused_flags;
  assign unused_flags = alu_zr ^ alu_ng;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= 16'h0000;
      mcand_q   <= 16'h0000;
      mplier_q  <= 16'h0000;
      cnt_q     <= 4'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    alu_x     = 16'h0000;
    alu_y     = 16'h0000;
    ctrl      = CTRL_ZERO;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = 16'h0000;
          cnt_d    = 4'd0;
          state_d  = S_ADD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ADD: begin
        busy    = 1'b1;
        alu_x   = acc_q;
        alu_y   = mcand_q;
        // A clear multiplier bit still goes through the ALU as x & 0xFFFF.
        ctrl    = mplier_q[0] ? CTRL_ADD : CTRL_PASS_X;
        acc_d   = alu_out;
        state_d = S_DBL;
      end
      S_DBL: begin
        busy     = 1'b1;
        alu_x    = mcand_q;
        alu_y    = mcand_q;
        ctrl     = CTRL_ADD;
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d   = S_ADD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;
  assign product    = product_q;
  assign product_zr = (product_q == 16'h0000);
  assign product_ng = product_q[15];

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural Hack ALU attached to its ALU ports.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] product;
  logic        product_zr, product_ng;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic        alu_zr, alu_ng;
  logic [5:0]  ctrl_obs;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          busy_run = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  alu_mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .product_zr(product_zr), .product_ng(product_ng),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  assign ctrl_obs = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

  // Hack ALU behaviour
  logic [15:0] xz, xn, yz, yn, fo;
  always_comb begin
    xz      = alu_zx ? 16'h0000 : alu_x;
    xn      = alu_nx ? ~xz : xz;
    yz      = alu_zy ? 16'h0000 : alu_y;
    yn      = alu_ny ? ~yz : yz;
    fo      = alu_f ? (xn + yn) : (xn & yn);
    alu_out = alu_no ? ~fo : fo;
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  // Clock and cycle counter
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: start is raised at a negedge, so the accepting edge is the next posedge
  // and done is expected 33 cycles later.
  task automatic issue(input logic [15:0] ai, input logic [15:0] bi);
    logic [31:0] full;
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    full = {16'h0000, ai} * {16'h0000, bi};
    exp_q.push_back(full[15:0]);
    exp_cyc_q.push_back(cyc + 33);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          logic [15:0] e;
          int          ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("product", {16'h0, product}, {16'h0, e});
          chk("product_zr", {31'h0, product_zr}, {31'h0, (e == 16'h0000)});
          chk("product_ng", {31'h0, product_ng}, {31'h0, e[15]});
          chk("done_cycle", cyc, ec);
          chk("busy_len", busy_run, 32);
          chk("busy_in_done", {31'h0, busy}, 32'd0);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    #3;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_product", {16'h0, product}, 32'd0);
    chk("rst_zr", {31'h0, product_zr}, 32'd1);
    chk("rst_ng", {31'h0, product_ng}, 32'd0);
    chk("rst_ctrl", {26'h0, ctrl_obs}, 32'b101010);
    chk("rst_alu_xy", {alu_x, alu_y}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed operations
    issue(16'd3, 16'd5);
    chk("busy_first", {31'h0, busy}, 32'd1);
    wait_done();
    @(negedge clk);
    chk("idle_after_done", {31'h0, busy | done}, 32'd0);
    chk("idle_ctrl", {26'h0, ctrl_obs}, 32'b101010);

    issue(16'hFFFE, 16'd7);
    wait_done();
    @(negedge clk);
    issue(16'h0100, 16'h0100);
    wait_done();
    @(negedge clk);

    // ALU drive of the first few steps
    issue(16'h1234, 16'h0002);
    chk("add1_ctrl", {26'h0, ctrl_obs}, 32'b001100);
    chk("add1_x", {16'h0, alu_x}, 32'h0000);
    chk("add1_y", {16'h0, alu_y}, 32'h1234);
    chk("add1_out", {16'h0, alu_out}, 32'h0000);
    @(negedge clk);
    chk("dbl1_ctrl", {26'h0, ctrl_obs}, 32'b000010);
    chk("dbl1_xy", {alu_x, alu_y}, 32'h12341234);
    @(negedge clk);
    chk("add2_ctrl", {26'h0, ctrl_obs}, 32'b000010);
    chk("add2_y", {16'h0, alu_y}, 32'h2468);
    chk("add2_x", {16'h0, alu_x}, 32'h0000);
    wait_done();
    @(negedge clk);

    // start while busy is ignored
    issue(16'd2, 16'd3);
    repeat (8) @(negedge clk);
    a = 16'd9;
    b = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Reset abort in the middle of an operation
    issue(16'h1111, 16'h0007);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_product", {16'h0, product}, 32'd0);
    chk("abort_zr", {31'h0, product_zr}, 32'd1);
    chk("abort_ctrl", {26'h0, ctrl_obs}, 32'b101010);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_product_hold", {16'h0, product}, 32'd0);

    // Back-to-back with start held through DONE
    issue(16'd4, 16'd4);
    wait_done();
    begin
      a = 16'd6;
      b = 16'd7;
      start = 1'b1;
      exp_q.push_back(16'd42);
      exp_cyc_q.push_back(cyc + 33);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", {31'h0, busy}, 32'd1);
    end
    wait_done();
    @(negedge clk);

    // Randomized operations
    for (int i = 0; i < 14; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (i == 0) ra = 16'hFFFF;
      if (i == 1) rb = 16'hFFFF;
      if (i == 2) rb = 16'h0000;
      issue(ra, rb);
      wait_done();
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
